// File: rtl/fft_frame_ctrl_pkg.sv
// Shared definitions for the 8-point FFT frame controller and its neighbours.
// Holds the state encoding, default frame geometry and the controller defaults.
package fft_frame_ctrl_pkg;

    // One complex sample is an I/Q pair of SAMPLE_W bits each
    localparam int unsigned SAMPLE_W     = 16;
    localparam int unsigned N_POINTS     = 8;
    localparam int unsigned FRAME_W_DEF  = N_POINTS * 2 * SAMPLE_W;

    localparam int unsigned TIMEOUT_DEF  = 64;
    localparam int unsigned CNT_W_DEF    = 8;

    // 2-bit binary state encoding shared with the datapath status logic
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } fft_state_t;

    // Width of a counter that must hold 0 .. limit-1
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 2) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/fft_watchdog.sv
// Clearable up-counter that flags expiry in its TIMEOUT-th enabled cycle.
module fft_watchdog
    import fft_frame_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned TW = cnt_width(TIMEOUT);

    logic [TW-1:0] r_count;

    // Count enabled cycles since the last clear
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + TW'(1);
        end
    end

    assign o_expired = i_en && (r_count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the 8-point FFT: launches the core on each accepted
// frame, waits for completion under a watchdog, then hands the result to the
// serializer. Frames arriving while busy are dropped and counted.
// Optional build macro: FFT_FRAME_CTRL_SKID_EN adds a one-entry skid buffer.
module fft_frame_ctrl
    import fft_frame_ctrl_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_valid,
    input  logic [FRAME_W-1:0] frame_in,
    output logic               fft_start,
    output logic [FRAME_W-1:0] fft_data,
    input  logic               fft_done,
    input  logic [FRAME_W-1:0] fft_result,
    output logic               ser_load,
    output logic [FRAME_W-1:0] ser_data,
    input  logic               ser_busy,
    output logic               busy,
    output logic [CNT_W-1:0]   drop_count,
    output logic               timeout_err
);

    fft_state_t         r_state;
    logic               r_fft_start;
    logic               r_busy;
    logic [FRAME_W-1:0] r_fft_data;
    logic [FRAME_W-1:0] r_ser_data;
    logic [CNT_W-1:0]   r_drop_count;
    logic               r_timeout_err;

    logic               w_launch;
    logic [FRAME_W-1:0] w_launch_data;
    logic               w_drop;
    logic               w_expired;

    // Watchdog is cleared on launch and runs only while waiting on the core
    fft_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_clr     (r_state == ST_START),
        .i_en      (r_state == ST_WAIT),
        .o_expired (w_expired)
    );

`ifdef FFT_FRAME_CTRL_SKID_EN
    logic               r_skid_full;
    logic [FRAME_W-1:0] r_skid_data;
    logic               w_skid_wr;

    // A parked frame always launches before a newly arriving one
    assign w_launch      = (r_state == ST_IDLE) && (r_skid_full || frame_valid);
    assign w_launch_data = r_skid_full ? r_skid_data : frame_in;
    assign w_drop        = frame_valid && (r_state != ST_IDLE) && r_skid_full;
    assign w_skid_wr     = frame_valid &&
                           (((r_state != ST_IDLE) && !r_skid_full) ||
                            ((r_state == ST_IDLE) && r_skid_full));

    // Skid entry: park a frame while busy, refill in the cycle it drains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skid_full <= 1'b0;
            r_skid_data <= '0;
        end else if (w_skid_wr) begin
            r_skid_full <= 1'b1;
            r_skid_data <= frame_in;
        end else if ((r_state == ST_IDLE) && r_skid_full) begin
            r_skid_full <= 1'b0;
        end
    end
`else
    assign w_launch      = (r_state == ST_IDLE) && frame_valid;
    assign w_launch_data = frame_in;
    assign w_drop        = frame_valid && (r_state != ST_IDLE);
`endif

    // Frame sequencing FSM with registered status outputs and drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_fft_start   <= 1'b0;
            r_busy        <= 1'b0;
            r_fft_data    <= '0;
            r_ser_data    <= '0;
            r_drop_count  <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_fft_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_fft_data  <= w_launch_data;
                        r_fft_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_START;
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done in the expiry cycle still completes the frame
                    if (fft_done) begin
                        r_ser_data <= fft_result;
                        r_state    <= ST_OUT;
                    end else if (w_expired) begin
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_OUT: begin
                    if (!ser_busy) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_drop && (r_drop_count != {CNT_W{1'b1}})) begin
                r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end
    end

    // Load is decoded so it fires in the first cycle the serializer is free
    assign ser_load    = (r_state == ST_OUT) && !ser_busy;
    assign fft_start   = r_fft_start;
    assign busy        = r_busy;
    assign fft_data    = r_fft_data;
    assign ser_data    = r_ser_data;
    assign drop_count  = r_drop_count;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl (default build, no skid buffer).
module tb_fft_frame_ctrl;

    localparam int FW = 256;
    localparam int TO = 64;
    localparam int CW = 8;
    localparam int DROP_MAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            frame_valid;
    logic [FW-1:0]   frame_in;
    logic            fft_start;
    logic [FW-1:0]   fft_data;
    logic            fft_done;
    logic [FW-1:0]   fft_result;
    logic            ser_load;
    logic [FW-1:0]   ser_data;
    logic            ser_busy;
    logic            busy;
    logic [CW-1:0]   drop_count;
    logic            timeout_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: what the frame is doing, at transaction level
    bit            m_launch;
    bit            m_wait;
    bit            m_hold;
    bit            m_terr;
    int            m_age;
    int            m_drops;
    logic [FW-1:0] m_fdata;
    logic [FW-1:0] m_sdata;

    typedef struct {
        bit fv;
        bit dn;
        bit sb;
        bit e_start;
        bit e_load;
        bit e_busy;
    } vec_t;

    vec_t tbl[12];

    fft_frame_ctrl #(
        .FRAME_W (FW),
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_valid (frame_valid),
        .frame_in    (frame_in),
        .fft_start   (fft_start),
        .fft_data    (fft_data),
        .fft_done    (fft_done),
        .fft_result  (fft_result),
        .ser_load    (ser_load),
        .ser_data    (ser_data),
        .ser_busy    (ser_busy),
        .busy        (busy),
        .drop_count  (drop_count),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] fill(input logic [7:0] b);
        logic [FW-1:0] f;
        for (int i = 0; i < FW / 8; i++) f[i*8 +: 8] = b;
        return f;
    endfunction

    function automatic logic [FW-1:0] rnd_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    task automatic model_reset();
        m_launch = 0; m_wait = 0; m_hold = 0; m_terr = 0;
        m_age = 0; m_drops = 0; m_fdata = '0; m_sdata = '0;
    endtask

    // One clock: drive at negedge, compare against the model, advance the model
    task automatic cyc(input bit fv, input logic [FW-1:0] fin, input bit dn,
                       input logic [FW-1:0] res, input bit sb);
        bit drop;
        @(negedge clk);
        frame_valid = fv; frame_in = fin; fft_done = dn; fft_result = res; ser_busy = sb;
        #1;
        chk("fft_start",   FW'(fft_start),   FW'(m_launch));
        chk("busy",        FW'(busy),        FW'(m_launch | m_wait | m_hold));
        chk("ser_load",    FW'(ser_load),    FW'(m_hold & ~sb));
        chk("fft_data",    fft_data,         m_fdata);
        chk("ser_data",    ser_data,         m_sdata);
        chk("drop_count",  FW'(drop_count),  FW'(m_drops));
        chk("timeout_err", FW'(timeout_err), FW'(m_terr));
        drop = 0;
        if (m_launch) begin
            m_launch = 0; m_wait = 1; m_age = 0; drop = fv;
        end else if (m_wait) begin
            drop = fv;
            if (dn) begin
                m_sdata = res; m_wait = 0; m_hold = 1;
            end else if (m_age == TO - 1) begin
                m_terr = 1; m_wait = 0;
            end else begin
                m_age++;
            end
        end else if (m_hold) begin
            drop = fv;
            if (!sb) m_hold = 0;
        end else if (fv) begin
            m_fdata = fin; m_launch = 1;
        end
        if (drop && m_drops < DROP_MAX) m_drops++;
    endtask

    task automatic idle_cyc();
        cyc(0, '0, 0, '0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; frame_valid = 0; frame_in = '0; fft_done = 0; fft_result = '0; ser_busy = 0;
        #1;
        model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        int first_err;
        logic [FW-1:0] r2;
        reset = 1; frame_valid = 0; frame_in = '0; fft_done = 0; fft_result = '0; ser_busy = 0;
        model_reset();
        #12;
        chk("rst_fft_data",    fft_data, '0);
        chk("rst_ser_data",    ser_data, '0);
        chk("rst_drop_count",  FW'(drop_count), '0);
        chk("rst_busy_start",  FW'({busy, fft_start, ser_load, timeout_err}), '0);
        @(negedge clk);
        reset = 0;

        // Single frame, core answers 8 cycles after start
        for (int i = 0; i < 12; i++) tbl[i] = '{0, 0, 0, 0, 0, 1};
        tbl[0]  = '{1, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 1, 0, 1};
        tbl[9]  = '{0, 1, 0, 0, 0, 1};
        tbl[10] = '{0, 0, 0, 0, 1, 1};
        tbl[11] = '{0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].fv, fill(8'hA5), tbl[i].dn, fill(8'h5A), tbl[i].sb);
            chk($sformatf("tbl%0d_start", i), FW'(fft_start), FW'(tbl[i].e_start));
            chk($sformatf("tbl%0d_load", i),  FW'(ser_load),  FW'(tbl[i].e_load));
            chk($sformatf("tbl%0d_busy", i),  FW'(busy),      FW'(tbl[i].e_busy));
        end
        chk("single_fft_data", fft_data, fill(8'hA5));
        chk("single_ser_data", ser_data, fill(8'h5A));
        chk("single_drops",    FW'(drop_count), '0);

        // Serializer backpressure around done
        r2 = rnd_frame();
        cyc(1, fill(8'h11), 0, '0, 0);
        cyc(0, '0, 0, '0, 1);
        cyc(0, '0, 0, '0, 1);
        cyc(0, '0, 1, r2, 1);
        for (int i = 0; i < 20; i++) begin
            cyc(0, '0, 0, '0, 1);
            chk("bp_no_load", FW'(ser_load), '0);
            chk("bp_busy",    FW'(busy), FW'(1));
            chk("bp_data",    ser_data, r2);
        end
        cyc(0, '0, 0, '0, 0);
        chk("bp_load", FW'(ser_load), FW'(1));
        idle_cyc();
        chk("bp_idle", FW'(busy), '0);

        // Drops during WAIT, then saturation while held in OUT
        do_reset();
        cyc(1, fill(8'hC3), 0, '0, 0);
        idle_cyc();
        for (int i = 0; i < 3; i++) cyc(1, rnd_frame(), 0, '0, 0);
        idle_cyc();
        chk("drop3_count", FW'(drop_count), FW'(3));
        chk("drop3_data",  fft_data, fill(8'hC3));
        cyc(0, '0, 1, fill(8'h3C), 1);
        for (int i = 0; i < 300; i++) cyc(1, rnd_frame(), 0, '0, 1);
        idle_cyc();
        chk("drop_sat", FW'(drop_count), FW'(DROP_MAX));
        chk("drop_sat_data", fft_data, fill(8'hC3));
        idle_cyc();

        // Watchdog with a core that never answers
        do_reset();
        cyc(1, fill(8'h77), 0, '0, 0);
        idle_cyc();
        first_err = -1;
        for (int j = 0; j < TO + 8; j++) begin
            idle_cyc();
            if (ser_load) chk("wd_no_load", FW'(ser_load), '0);
            if (timeout_err && first_err < 0) first_err = j;
        end
        chk("wd_latency", FW'(first_err), FW'(TO));
        chk("wd_idle", FW'(busy), '0);
        cyc(1, fill(8'h88), 0, '0, 0);
        idle_cyc();
        chk("wd_relaunch", FW'(fft_start), FW'(1));
        chk("wd_relaunch_data", fft_data, fill(8'h88));
        chk("wd_sticky", FW'(timeout_err), FW'(1));
        cyc(0, '0, 1, fill(8'h99), 0);
        idle_cyc();
        idle_cyc();

        // Asynchronous reset three cycles after fft_start
        do_reset();
        cyc(1, fill(8'hE1), 0, '0, 0);
        cyc(0, '0, 0, '0, 0);
        cyc(0, '0, 0, '0, 0);
        cyc(0, '0, 0, '0, 0);
        cyc(0, '0, 0, '0, 0);
        #1 reset = 1;
        #1;
        chk("arst_fft_data", fft_data, '0);
        chk("arst_outs", FW'({busy, fft_start, ser_load, timeout_err}), '0);
        chk("arst_drops", FW'(drop_count), '0);
        model_reset();
        @(negedge clk);
        reset = 0;
        cyc(0, '0, 1, fill(8'hEE), 0);
        idle_cyc();
        chk("late_done_no_load", FW'(ser_load), '0);
        chk("late_done_idle", FW'(busy), '0);

        // Randomized traffic against the model, with hang phases for the watchdog
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            bit hang;
            hang = ((c / 250) % 3) == 2;
            cyc(($urandom_range(5) == 0), rnd_frame(),
                !hang && ($urandom_range(9) == 0), rnd_frame(),
                ($urandom_range(1) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
